// File: rtl/harris_row_feeder_if.sv
// Frame-RAM read bus and detector pixel stream used by harris_row_feeder.
interface harris_row_feeder_if #(
    parameter int ADDR_W = 19
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic [7:0]        pixel;
    logic              pixel_valid;

    // Feeder side: drives reads and the pixel stream.
    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rdata,
        output pixel,
        output pixel_valid
    );

    // Memory/detector side.
    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rdata,
        input  pixel,
        input  pixel_valid
    );
endinterface

// File: rtl/harris_row_feeder.sv
// Streams a greyscale frame from a synchronous-read RAM to the Harris detector:
// preloads PRELOAD_ROWS rows back-to-back, then one row per row_req rising edge.
module harris_row_feeder #(
    parameter int ROW_LEN      = 480,
    parameter int NUM_ROWS     = 640,
    parameter int PRELOAD_ROWS = 7,
    parameter int ADDR_W       = 19
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       row_req,
    harris_row_feeder_if.master        bus,
    output logic                       busy,
    output logic                       frame_done,
    output logic [9:0]                 rows_sent,
    output logic                       req_overrun
);
    localparam int               COL_W      = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(ROW_LEN - 1);
    localparam logic [9:0]       ROWS_TOTAL = 10'(NUM_ROWS);
    localparam logic [9:0]       ROWS_PRE   = 10'(PRELOAD_ROWS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRELOAD,
        S_WAIT_REQ,
        S_ROW,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [9:0]        rows_sent_q, rows_sent_d;
    logic              pending_q, pending_d;
    logic              overrun_q, overrun_d;
    logic              row_req_q, row_req_d;
    logic              rd1_q, rd1_d;
    logic [7:0]        pixel_q, pixel_d;
    logic              pixel_valid_q, pixel_valid_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;

    logic              row_edge;
    logic              issue;
    logic              preload_phase;
    logic [ADDR_W-1:0] cnt_base;
    logic [COL_W-1:0]  col_base;
    logic [9:0]        rows_base;
    logic [9:0]        rows_new;

    // Next-state, read issue, request bookkeeping and data pipeline.
    // ROW spends one idle cycle before its first read; combined with the FSM
    // leaving a burst on the edge that issues its last read, both a fresh
    // request (R+1) and a pending one (2 cycles after the last read) line up.
    always_comb begin
        row_edge      = row_req & ~row_req_q;
        state_d       = state_q;
        rd_en_d       = 1'b0;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        col_d         = col_q;
        rows_sent_d   = rows_sent_q;
        pending_d     = pending_q;
        overrun_d     = overrun_q;
        frame_done_d  = 1'b0;
        issue         = 1'b0;
        preload_phase = 1'b0;
        cnt_base      = cnt_q;
        col_base      = col_q;
        rows_base     = rows_sent_q;
        rows_new      = rows_sent_q;

        if ((state_q == S_PRELOAD || state_q == S_ROW) && row_edge) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start && !busy_q) begin
                    state_d       = S_PRELOAD;
                    issue         = 1'b1;
                    preload_phase = 1'b1;
                    cnt_base      = '0;
                    col_base      = '0;
                    rows_base     = '0;
                    rows_sent_d   = '0;
                    pending_d     = 1'b0;
                    overrun_d     = 1'b0;
                end
            end
            S_PRELOAD: begin
                issue         = 1'b1;
                preload_phase = 1'b1;
            end
            S_WAIT_REQ: begin
                if (pending_q || row_edge) begin
                    state_d   = S_ROW;
                    pending_d = pending_q & row_edge;
                end
            end
            S_ROW: issue = 1'b1;
            S_DONE: begin
                if (!rd_en_q && !rd1_q) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            rd_en_d = 1'b1;
            addr_d  = cnt_base;
            cnt_d   = cnt_base + ADDR_W'(1);
            if (col_base == COL_LAST) begin
                col_d       = '0;
                rows_new    = rows_base + 10'd1;
                rows_sent_d = rows_new;
                if (rows_new >= ROWS_TOTAL)                    state_d = S_DONE;
                else if (preload_phase && rows_new < ROWS_PRE) state_d = S_PRELOAD;
                else                                           state_d = S_WAIT_REQ;
            end else begin
                col_d = col_base + COL_W'(1);
            end
        end

        row_req_d     = row_req;
        rd1_d         = rd_en_q;
        pixel_valid_d = rd1_q;
        pixel_d       = rd1_q ? bus.mem_rdata : pixel_q;
        busy_d        = (state_d != S_IDLE) || frame_done_d;
    end

    // State and output registers; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rd_en_q       <= 1'b0;
            addr_q        <= '0;
            cnt_q         <= '0;
            col_q         <= '0;
            rows_sent_q   <= '0;
            pending_q     <= 1'b0;
            overrun_q     <= 1'b0;
            row_req_q     <= 1'b0;
            rd1_q         <= 1'b0;
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_en_q       <= rd_en_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            col_q         <= col_d;
            rows_sent_q   <= rows_sent_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            row_req_q     <= row_req_d;
            rd1_q         <= rd1_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_addr    = addr_q;
    assign bus.pixel       = pixel_q;
    assign bus.pixel_valid = pixel_valid_q;
    assign busy            = busy_q;
    assign frame_done      = frame_done_q;
    assign rows_sent       = rows_sent_q;
    assign req_overrun     = overrun_q;
endmodule

// File: tb/tb_harris_row_feeder.sv
// Directed bench for harris_row_feeder with ROW_LEN=4, NUM_ROWS=6, PRELOAD_ROWS=3
// and a frame RAM holding mem[i]=i.
module tb_harris_row_feeder;
    localparam int ROW_LEN      = 4;
    localparam int NUM_ROWS     = 6;
    localparam int PRELOAD_ROWS = 3;
    localparam int ADDR_W       = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       row_req = 1'b0;
    logic       busy;
    logic       frame_done;
    logic [9:0] rows_sent;
    logic       req_overrun;

    harris_row_feeder_if #(.ADDR_W(ADDR_W)) bus ();

    harris_row_feeder #(
        .ROW_LEN(ROW_LEN),
        .NUM_ROWS(NUM_ROWS),
        .PRELOAD_ROWS(PRELOAD_ROWS),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .row_req(row_req),
        .bus(bus),
        .busy(busy),
        .frame_done(frame_done),
        .rows_sent(rows_sent),
        .req_overrun(req_overrun)
    );

    always #5 clk = ~clk;

    // Synchronous-read frame RAM, mem[i] = i.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= 8'(bus.mem_addr);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         q_pix[$];
    int         q_cyc[$];
    int         fd_count = 0;
    int         fd_cyc = 0;
    logic       fd_busy = 1'b0;

    // Stream monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.pixel_valid) begin
            q_pix.push_back(int'(bus.pixel));
            q_cyc.push_back(cyc);
        end
        if (frame_done) begin
            fd_count = fd_count + 1;
            fd_cyc   = cyc;
            fd_busy  = busy;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        q_pix.delete();
        q_cyc.delete();
        fd_count = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        row_req = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if ({bus.mem_rd_en, bus.mem_addr, bus.pixel, bus.pixel_valid, busy, frame_done,
             rows_sent, req_overrun} !== '0)
            $display("FAIL reset_held: outputs=%b required all zero",
                     {bus.mem_rd_en, bus.mem_addr, bus.pixel, bus.pixel_valid, busy,
                      frame_done, rows_sent, req_overrun});
        else n_pass++;
        reset = 1'b0;
        step();
        step();
        n_checks++;
        if ({bus.mem_rd_en, bus.pixel_valid, busy, frame_done, rows_sent} !== '0)
            $display("FAIL reset_idle: rd_en=%b valid=%b busy=%b done=%b rows=%0d required 0",
                     bus.mem_rd_en, bus.pixel_valid, busy, frame_done, rows_sent);
        else n_pass++;
    endtask

    task automatic test_preload();
        int e;
        do_reset();
        clear_mon();
        pulse_start();
        e = cyc;
        n_checks++;
        if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 5'd0)
            $display("FAIL preload_first_read: rd_en=%b addr=%0d required 1/0",
                     bus.mem_rd_en, bus.mem_addr);
        else n_pass++;
        step();
        n_checks++;
        if (bus.pixel_valid !== 1'b0)
            $display("FAIL preload_latency: valid=%b at E+1 required 0", bus.pixel_valid);
        else n_pass++;
        repeat (17) step();
        n_checks++;
        if (q_pix.size() != 12)
            $display("FAIL preload_count: got %0d pixels required 12", q_pix.size());
        else begin
            n_pass++;
            for (int i = 0; i < 12; i++) begin
                n_checks++;
                if (q_pix[i] != i || q_cyc[i] != e + 2 + i)
                    $display("FAIL preload_pixel%0d: value=%0d cycle=%0d required %0d at %0d",
                             i, q_pix[i], q_cyc[i], i, e + 2 + i);
                else n_pass++;
            end
        end
        n_checks++;
        if (rows_sent !== 10'd3 || busy !== 1'b1 || bus.pixel_valid !== 1'b0)
            $display("FAIL preload_status: rows=%0d busy=%b valid=%b required 3/1/0",
                     rows_sent, busy, bus.pixel_valid);
        else n_pass++;
    endtask

    task automatic test_row_request();
        int r;
        clear_mon();
        row_req = 1'b1;
        step();
        r = cyc;
        n_checks++;
        if (bus.mem_rd_en !== 1'b0)
            $display("FAIL row_rd_early: rd_en=%b at R required 0", bus.mem_rd_en);
        else n_pass++;
        step();
        n_checks++;
        if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 5'd12)
            $display("FAIL row_rd_start: rd_en=%b addr=%0d at R+1 required 1/12",
                     bus.mem_rd_en, bus.mem_addr);
        else n_pass++;
        row_req = 1'b0;
        repeat (10) step();
        n_checks++;
        if (q_pix.size() != 4)
            $display("FAIL row_count: got %0d pixels required 4", q_pix.size());
        else begin
            n_pass++;
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (q_pix[i] != 12 + i || q_cyc[i] != r + 3 + i)
                    $display("FAIL row_pixel%0d: value=%0d cycle=%0d required %0d at %0d",
                             i, q_pix[i], q_cyc[i], 12 + i, r + 3 + i);
                else n_pass++;
            end
        end
        n_checks++;
        if (rows_sent !== 10'd4)
            $display("FAIL row_rows_sent: got %0d required 4", rows_sent);
        else n_pass++;
    endtask

    task automatic test_early_request();
        do_reset();
        clear_mon();
        pulse_start();
        step();
        step();
        row_req = 1'b1;
        repeat (25) step();
        n_checks++;
        if (q_pix.size() != 16)
            $display("FAIL early_count: got %0d pixels required 16", q_pix.size());
        else begin
            n_pass++;
            for (int i = 0; i < 16; i++) begin
                n_checks++;
                if (q_pix[i] != i)
                    $display("FAIL early_pixel%0d: value=%0d required %0d", i, q_pix[i], i);
                else n_pass++;
            end
            n_checks++;
            if (q_cyc[11] != q_cyc[0] + 11 || q_cyc[12] != q_cyc[11] + 2 ||
                q_cyc[15] != q_cyc[12] + 3)
                $display("FAIL early_gap: cycles p0=%0d p11=%0d p12=%0d p15=%0d required 1-cycle gap",
                         q_cyc[0], q_cyc[11], q_cyc[12], q_cyc[15]);
            else n_pass++;
        end
        n_checks++;
        if (req_overrun !== 1'b0 || rows_sent !== 10'd4)
            $display("FAIL early_status: overrun=%b rows=%0d required 0/4", req_overrun, rows_sent);
        else n_pass++;
        row_req = 1'b0;
        step();
    endtask

    task automatic test_overrun_completion();
        clear_mon();
        row_req = 1'b1; step();
        row_req = 1'b0; step();
        row_req = 1'b1; step();
        row_req = 1'b0; step();
        row_req = 1'b1; step();
        row_req = 1'b0;
        repeat (15) step();
        n_checks++;
        if (req_overrun !== 1'b1)
            $display("FAIL overrun_flag: got %b required 1", req_overrun);
        else n_pass++;
        n_checks++;
        if (q_pix.size() != 8)
            $display("FAIL overrun_count: got %0d pixels required 8", q_pix.size());
        else begin
            n_pass++;
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (q_pix[i] != 16 + i)
                    $display("FAIL overrun_pixel%0d: value=%0d required %0d", i, q_pix[i], 16 + i);
                else n_pass++;
            end
            n_checks++;
            if (q_cyc[4] != q_cyc[3] + 2)
                $display("FAIL pending_gap: p19 at %0d p20 at %0d required +2", q_cyc[3], q_cyc[4]);
            else n_pass++;
            n_checks++;
            if (fd_count != 1 || fd_cyc != q_cyc[7] + 1 || fd_busy !== 1'b1)
                $display("FAIL frame_done: pulses=%0d cycle=%0d busy=%b required 1 at %0d busy 1",
                         fd_count, fd_cyc, fd_busy, q_cyc[7] + 1);
            else n_pass++;
        end
        n_checks++;
        if (busy !== 1'b0 || rows_sent !== 10'd6)
            $display("FAIL done_status: busy=%b rows=%0d required 0/6", busy, rows_sent);
        else n_pass++;
        row_req = 1'b1; step();
        row_req = 1'b0;
        repeat (8) step();
        n_checks++;
        if (q_pix.size() != 8 || bus.mem_rd_en !== 1'b0)
            $display("FAIL after_done: pixels=%0d rd_en=%b required 8/0", q_pix.size(), bus.mem_rd_en);
        else n_pass++;
    endtask

    task automatic test_reset_restart();
        do_reset();
        clear_mon();
        pulse_start();
        repeat (5) step();
        reset = 1'b1;
        step();
        n_checks++;
        if ({bus.mem_rd_en, bus.mem_addr, bus.pixel, bus.pixel_valid, busy, frame_done,
             rows_sent, req_overrun} !== '0)
            $display("FAIL midframe_reset: outputs=%b required all zero",
                     {bus.mem_rd_en, bus.mem_addr, bus.pixel, bus.pixel_valid, busy,
                      frame_done, rows_sent, req_overrun});
        else n_pass++;
        reset = 1'b0;
        step();
        step();
        n_checks++;
        if (bus.pixel_valid !== 1'b0 || bus.mem_rd_en !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_discard: valid=%b rd_en=%b busy=%b required 0",
                     bus.pixel_valid, bus.mem_rd_en, busy);
        else n_pass++;
        clear_mon();
        pulse_start();
        repeat (17) step();
        n_checks++;
        if (q_pix.size() != 12)
            $display("FAIL restart_count: got %0d pixels required 12", q_pix.size());
        else begin
            n_pass++;
            for (int i = 0; i < 12; i++) begin
                n_checks++;
                if (q_pix[i] != i)
                    $display("FAIL restart_pixel%0d: value=%0d required %0d", i, q_pix[i], i);
                else n_pass++;
            end
        end
    endtask

    task automatic test_start_while_busy();
        do_reset();
        clear_mon();
        pulse_start();
        repeat (3) step();
        pulse_start();
        repeat (15) step();
        n_checks++;
        if (q_pix.size() != 12)
            $display("FAIL busy_start_count: got %0d pixels required 12", q_pix.size());
        else begin
            n_pass++;
            for (int i = 0; i < 12; i++) begin
                n_checks++;
                if (q_pix[i] != i || q_cyc[i] != q_cyc[0] + i)
                    $display("FAIL busy_start_pixel%0d: value=%0d cycle=%0d required %0d at %0d",
                             i, q_pix[i], q_cyc[i], i, q_cyc[0] + i);
                else n_pass++;
            end
        end
        n_checks++;
        if (rows_sent !== 10'd3 || busy !== 1'b1)
            $display("FAIL busy_start_status: rows=%0d busy=%b required 3/1", rows_sent, busy);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_preload();
        test_row_request();
        test_early_request();
        test_overrun_completion();
        test_reset_restart();
        test_start_while_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/harris_row_feeder.md
# harris_row_feeder

Frame-buffer-to-detector pixel transmitter: the sending end of the `pixel`/`pixel_valid` stream consumed by `harrisDetector`.
- On `start`, it reads an 8-bit greyscale frame from a synchronous-read memory in row-major order.
- It bursts the first `PRELOAD_ROWS` rows back-to-back to fill the detector's line buffers.
- It then sends exactly one further row per rising edge of the detector's row-request interrupt, until the frame is exhausted.
- It replaces the file-driven stimulus used today and sits between the frame RAM and the detector.

## Interface
Parameters:
- `ROW_LEN`, 480: pixels per row.
- `NUM_ROWS`, 640: rows per frame.
- `PRELOAD_ROWS`, 7: rows sent unconditionally after `start`.
- `ADDR_W`, 19: memory address width; must hold `NUM_ROWS*ROW_LEN-1`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse that begins a frame; ignored while `busy`.
- `row_req` in 1: detector interrupt; each rising edge requests one row.
- `mem_rd_en` out 1: memory read strobe.
- `mem_addr` out ADDR_W: read address.
- `mem_rdata` in 8: read data, valid the cycle after `mem_rd_en`.
- `pixel` out 8: pixel to detector.
- `pixel_valid` out 1: pixel qualifier.
- `busy` out 1: frame in progress.
- `frame_done` out 1: one-cycle pulse after the last pixel.
- `rows_sent` out 10: rows fully issued this frame.
- `req_overrun` out 1: sticky; a request arrived while one was already pending.

## Operation
- Reset values (all outputs registered): every output is 0. FSM goes to IDLE. Pending flag and the `row_req` history register clear.
- States and transitions:
  - IDLE → PRELOAD on `start`. This clears `rows_sent`, `req_overrun`, the pending flag and the address counter.
  - PRELOAD issues `PRELOAD_ROWS*ROW_LEN` consecutive reads with no gaps, then goes to WAIT_REQ. If `NUM_ROWS <= PRELOAD_ROWS`, it issues the whole frame and goes to DONE.
  - WAIT_REQ → ROW when the pending flag is set or a `row_req` edge is detected this cycle; the pending flag is consumed.
  - ROW issues `ROW_LEN` consecutive reads. It then goes to WAIT_REQ, or to DONE if `rows_sent` reaches `NUM_ROWS`.
  - DONE waits for the pipeline to drain, pulses `frame_done`, then returns to IDLE.
- Edge detect: a `row_req` edge is `row_req & ~row_req_q`.
  - In PRELOAD/ROW, an edge sets pending. An edge while pending is already set is dropped and sets `req_overrun`.
  - In WAIT_REQ, an edge is used immediately.
  - In IDLE/DONE, edges are ignored.
- Addressing: linear counter from 0 to `NUM_ROWS*ROW_LEN-1`, incremented per read, never wraps within a frame. `rows_sent` increments on the last read of each row, including each preload row.
- Data path:
  - `pixel_valid` = `mem_rd_en` delayed 2 cycles.
  - `pixel` = `mem_rdata` registered once, so it aligns with `pixel_valid`.
  - `pixel` holds its last value when not valid.
- `busy` is high from the cycle after `start` is accepted until the cycle `frame_done` pulses (inclusive).
- `reset` mid-frame aborts immediately: all outputs go to 0 next cycle and in-flight pipeline data is discarded.

## Timing
- `start` sampled at edge E: `mem_rd_en`=1 and `mem_addr`=0 are visible after E. First `pixel_valid` is visible after E+2.
- Preload: `pixel_valid` high for exactly `PRELOAD_ROWS*ROW_LEN` consecutive cycles.
- Row burst: `pixel_valid` high for exactly `ROW_LEN` consecutive cycles, with at least 1 low cycle between any two bursts.
- Pending request: when a request is already pending at the end of a burst, the next burst's `mem_rd_en` starts 2 cycles after the previous burst's last `mem_rd_en`.
- Request in WAIT_REQ: an edge sampled at R gives `mem_rd_en` after R+1 and `pixel_valid` after R+3.
- `frame_done` is high in the cycle after the final `pixel_valid` cycle.
- Simultaneous `start` and `row_req` edge in IDLE: `start` is accepted; the edge is ignored.

## Test plan
All scenarios use `ROW_LEN`=4, `NUM_ROWS`=6, `PRELOAD_ROWS`=3, and memory content mem[i]=i.
- Preload: pulse `start` → 12 consecutive `pixel_valid` carrying 0..11. Then `pixel_valid` stays 0, `rows_sent`=3, `busy`=1.
- Row on request: single `row_req` rising edge → 4 valid pixels 12..15 starting 3 cycles after the edge; `rows_sent`=4.
- Early request: hold `row_req` high during preload, then hold it high again → exactly one extra row (12..15) after the preload with a 1-cycle gap. A level held high does not retrigger; `req_overrun`=0.
- Overrun and completion:
  - Two edges during one burst → `req_overrun`=1, and only one follow-up row is sent.
  - After row 6 (pixels 20..23), `frame_done` pulses once, `busy`=0, and further `row_req` edges produce no pixels.
- Reset and restart: assert `reset` mid-row → next cycle all outputs are 0. A new `start` restarts from pixel 0.
- `start` while `busy` → ignored; the address sequence is unaffected.
